writeback_ctrl: RTL and testbench

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/writeback_ctrl_pkg.sv | 26 ++
 rtl/wb_hold.sv | 33 +++
 rtl/writeback_ctrl.sv | 158 +++++++++++++++
 tb/tb_writeback_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_ctrl_pkg.sv
// Shared types and constants for the writeback controller: load FSM encoding,
// register-file index/data widths and the default load timeout.
package writeback_ctrl_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StWrite = 2'd2
    } ld_state_e;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // One register-file write: data plus destination index.
    typedef struct packed {
        data_t data;
        idx_t  dest;
    } wb_item_t;

endpackage

// File: rtl/wb_hold.sv
// One-entry holding buffer for a register-file write that lost arbitration.
// Push wins over pop; the controller never requests both in one cycle.
module wb_hold
    import writeback_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  wb_item_t push_item,
    input  logic     pop,
    output logic     full,
    output wb_item_t item
);

    logic     full_q;
    wb_item_t item_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            item_q <= '0;
        end else if (push) begin
            full_q <= 1'b1;
            item_q <= push_item;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign item = item_q;

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback controller: merges a blocking memory-load path and an ALU result path
// into a single register-file write port, with load timeout and ALU hold buffer.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [IDX_W-1:0]  ld_dest,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [IDX_W-1:0]  alu_dest,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              LDRsel,
    output logic [DATA_W-1:0] LDRdata,
    output logic [IDX_W-1:0]  destination,
    output logic              ld_err
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q;
    idx_t              dest_q;
    logic              sel_q, sel_d;
    wb_item_t          wr_q, wr_d;
    logic              err_q, err_d;

    logic              ld_accept;
    logic              alu_accept;
    logic              load_done;
    logic              timed_out;

    logic              hold_push;
    logic              hold_pop;
    logic              hold_full;
    wb_item_t          hold_item;

    assign ld_accept  = ld_valid && ld_ready;
    assign alu_accept = alu_valid && alu_ready;
    assign load_done  = (state_q == StWait) && mem_ack;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    // An ack on the cycle the counter hits the limit still counts as success.
    assign timed_out  = (state_q == StWait) && !mem_ack && (cnt_inc == TimeoutCnt);

    // ---------------------------------------------------------------- load FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ld_accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d = StWrite;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The ack-cycle collision with an ALU result is absorbed by the hold buffer,
    // so the ALU path only stalls while that buffer is occupied.
    always_comb begin
        ld_ready  = (state_q == StIdle);
        mem_req   = (state_q == StWait);
        alu_ready = !hold_full;
    end

    // ------------------------------------------------------ write arbitration
    always_comb begin
        hold_push = alu_accept && load_done;
        hold_pop  = hold_full;
        sel_d     = 1'b0;
        wr_d      = wr_q;
        if (load_done) begin
            sel_d       = 1'b1;
            wr_d.data   = mem_rdata;
            wr_d.dest   = dest_q;
        end else if (hold_full) begin
            sel_d       = 1'b1;
            wr_d        = hold_item;
        end else if (alu_accept) begin
            sel_d       = 1'b1;
            wr_d.data   = alu_result;
            wr_d.dest   = alu_dest;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ld_accept) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_inc;
        end
        err_d = timed_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
            dest_q <= '0;
            sel_q  <= 1'b0;
            wr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            wr_q  <= wr_d;
            err_q <= err_d;
            if (ld_accept) begin
                addr_q <= ld_addr;
                dest_q <= ld_dest;
            end
        end
    end

    wb_hold u_hold (
        .clk       (clk),
        .reset     (reset),
        .push      (hold_push),
        .push_item ('{data: alu_result, dest: alu_dest}),
        .pop       (hold_pop),
        .full      (hold_full),
        .item      (hold_item)
    );

    assign mem_addr    = addr_q;
    assign LDRsel      = sel_q;
    assign LDRdata     = wr_q.data;
    assign destination = wr_q.dest;
    assign ld_err      = err_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed, table-driven bench for writeback_ctrl (TIMEOUT = 4): one row per
// clock cycle with inputs and the outputs expected during that cycle.
module tb_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic [3:0]  ld_dest;
    logic        alu_valid, alu_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_dest;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;
    logic        LDRsel, ld_err;
    logic [31:0] LDRdata;
    logic [3:0]  destination;

    always #5 clk = ~clk;

    writeback_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_dest     (ld_dest),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_result  (alu_result),
        .alu_dest    (alu_dest),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .LDRsel      (LDRsel),
        .LDRdata     (LDRdata),
        .destination (destination),
        .ld_err      (ld_err)
    );

    typedef struct packed {
        logic lv; logic [31:0] la; logic [3:0] ld;
        logic av; logic [31:0] ar; logic [3:0] ad;
        logic ack; logic [31:0] rd;
    } in_t;

    typedef struct packed {
        logic lr; logic ar; logic req; logic [31:0] addr;
        logic sel; logic [31:0] data; logic [3:0] dest; logic err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];
    in_t  ni;
    int   checks = 0;
    int   errors = 0;

    function automatic in_t inp(input logic [31:0] lv, input logic [31:0] la,
                                input logic [31:0] ld, input logic [31:0] av,
                                input logic [31:0] ar, input logic [31:0] ad,
                                input logic [31:0] ack, input logic [31:0] rd);
        in_t r;
        r.lv = 1'(lv); r.la = la; r.ld = 4'(ld);
        r.av = 1'(av); r.ar = ar; r.ad = 4'(ad);
        r.ack = 1'(ack); r.rd = rd;
        return r;
    endfunction

    function automatic out_t outp(input logic [31:0] lr, input logic [31:0] ar,
                                  input logic [31:0] req, input logic [31:0] addr,
                                  input logic [31:0] sel, input logic [31:0] data,
                                  input logic [31:0] dest, input logic [31:0] err);
        out_t r;
        r.lr = 1'(lr); r.ar = 1'(ar); r.req = 1'(req); r.addr = addr;
        r.sel = 1'(sel); r.data = data; r.dest = 4'(dest); r.err = 1'(err);
        return r;
    endfunction

    function automatic out_t cur_out();
        out_t r;
        r.lr = ld_ready; r.ar = alu_ready; r.req = mem_req; r.addr = mem_addr;
        r.sel = LDRsel; r.data = LDRdata; r.dest = destination; r.err = ld_err;
        return r;
    endfunction

    task automatic drive(input in_t v);
        ld_valid = v.lv; ld_addr = v.la; ld_dest = v.ld;
        alu_valid = v.av; alu_result = v.ar; alu_dest = v.ad;
        mem_ack = v.ack; mem_rdata = v.rd;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = cur_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got rdy=%b%b req=%b addr=%h sel=%b data=%h dest=%h err=%b, %s",
                     name, act.lr, act.ar, act.req, act.addr, act.sel, act.data, act.dest,
                     act.err,
                     $sformatf("expected rdy=%b%b req=%b addr=%h sel=%b data=%h dest=%h err=%b",
                               exp.lr, exp.ar, exp.req, exp.addr, exp.sel, exp.data,
                               exp.dest, exp.err));
        end
    endtask

    initial begin
        ni = inp(0, 0, 0, 0, 0, 0, 0, 0);
        // ALU only
        vecs.push_back('{inp(0, 0, 0, 1, 'hAA, 3, 0, 0), outp(1, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 0, 1, 'hAA, 3, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 0, 0, 'hAA, 3, 0)});
        // Load, ack on cycle 3; acks outside WAIT are ignored
        vecs.push_back('{inp(1, 'h100, 5, 0, 0, 0, 0, 0), outp(1, 1, 0, 0, 0, 'hAA, 3, 0)});
        vecs.push_back('{ni, outp(0, 1, 1, 'h100, 0, 'hAA, 3, 0)});
        vecs.push_back('{ni, outp(0, 1, 1, 'h100, 0, 'hAA, 3, 0)});
        vecs.push_back('{inp(0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF),
                         outp(0, 1, 1, 'h100, 0, 'hAA, 3, 0)});
        vecs.push_back('{inp(0, 0, 0, 0, 0, 0, 1, 'h55),
                         outp(0, 1, 0, 'h100, 1, 'hDEADBEEF, 5, 0)});
        vecs.push_back('{inp(0, 0, 0, 0, 0, 0, 1, 'h12345678),
                         outp(1, 1, 0, 'h100, 0, 'hDEADBEEF, 5, 0)});
        // Conflict: ALU accepted in the ack cycle, then same-index back-to-back
        vecs.push_back('{inp(1, 'h200, 7, 0, 0, 0, 0, 0),
                         outp(1, 1, 0, 'h100, 0, 'hDEADBEEF, 5, 0)});
        vecs.push_back('{inp(0, 0, 0, 1, 'h22222222, 9, 1, 'h11111111),
                         outp(0, 1, 1, 'h200, 0, 'hDEADBEEF, 5, 0)});
        vecs.push_back('{inp(0, 0, 0, 1, 'h33, 2, 0, 0),
                         outp(0, 0, 0, 'h200, 1, 'h11111111, 7, 0)});
        vecs.push_back('{inp(0, 0, 0, 1, 'h44, 2, 0, 0),
                         outp(1, 1, 0, 'h200, 1, 'h22222222, 9, 0)});
        vecs.push_back('{inp(0, 0, 0, 1, 'h55, 2, 0, 0), outp(1, 1, 0, 'h200, 1, 'h44, 2, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 'h200, 1, 'h55, 2, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 'h200, 0, 'h55, 2, 0)});
        // Timeout after 4 WAIT cycles; ld_valid while busy is ignored
        vecs.push_back('{inp(1, 'h300, 'hA, 0, 0, 0, 0, 0), outp(1, 1, 0, 'h200, 0, 'h55, 2, 0)});
        vecs.push_back('{inp(1, 'h999, 1, 0, 0, 0, 0, 0), outp(0, 1, 1, 'h300, 0, 'h55, 2, 0)});
        for (int k = 0; k < 3; k++) vecs.push_back('{ni, outp(0, 1, 1, 'h300, 0, 'h55, 2, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 'h300, 0, 'h55, 2, 1)});
        vecs.push_back('{ni, outp(1, 1, 0, 'h300, 0, 'h55, 2, 0)});
        // ALU write during WAIT, then ack on the limit cycle counts as success
        vecs.push_back('{inp(1, 'h400, 'hB, 0, 0, 0, 0, 0), outp(1, 1, 0, 'h300, 0, 'h55, 2, 0)});
        vecs.push_back('{inp(0, 0, 0, 1, 'h66, 1, 0, 0), outp(0, 1, 1, 'h400, 0, 'h55, 2, 0)});
        vecs.push_back('{ni, outp(0, 1, 1, 'h400, 1, 'h66, 1, 0)});
        vecs.push_back('{ni, outp(0, 1, 1, 'h400, 0, 'h66, 1, 0)});
        vecs.push_back('{inp(0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D),
                         outp(0, 1, 1, 'h400, 0, 'h66, 1, 0)});
        vecs.push_back('{ni, outp(0, 1, 0, 'h400, 1, 'hCAFEF00D, 'hB, 0)});
        vecs.push_back('{ni, outp(1, 1, 0, 'h400, 0, 'hCAFEF00D, 'hB, 0)});

        drive(ni);
        #1 reset = 1'b1;
        #2 check_out("reset_async", outp(1, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_out("reset_state", outp(1, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].i);
            check_out($sformatf("row%0d", i), vecs[i].o);
            @(negedge clk);
        end

        // Reset mid-WAIT, then a stale ack after release
        drive(inp(1, 'h500, 6, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(ni);
        check_out("rst_wait", outp(0, 1, 1, 'h500, 0, 'hCAFEF00D, 'hB, 0));
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_out("rst_mid_wait", outp(1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;
        drive(inp(0, 0, 0, 0, 0, 0, 1, 'hBAD));
        @(negedge clk);
        check_out("rst_late_ack", outp(1, 1, 0, 0, 0, 0, 0, 0));
        drive(ni);
        @(negedge clk);
        check_out("rst_after", outp(1, 1, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
